register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter RoB_WIDTH, default 3, the RoB index width shared with the reorder buffer.
REQ-002 SHALL have clk_in  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have rst_in  input  1  reset, synchronous and active-high.
REQ-004 SHALL have rdy_in  input  1  global enable; low freezes all state.
REQ-005 SHALL have commit_en / commit_reg / commit_index / commit_data  input  1/5/RoB_WIDTH/32  RoB commit write port.
REQ-006 SHALL have rename_en / rename_reg / rename_index  input  1/5/RoB_WIDTH  dispatcher marks rename_reg as pending on RoB entry rename_index.
REQ-007 SHALL have flush_signal  input  1  RoB misprediction flush.
REQ-008 SHALL have rs1 / rs2  input  5 each  dispatcher source register numbers.
REQ-009 SHALL have rs1_busy / rs1_tag / rs1_value  output  1/RoB_WIDTH/32  combinational lookup result for rs1; rs2_busy / rs2_tag / rs2_value are identical for rs2.

Function
REQ-010 SHALL hold 32 entries, each with value[31:0], busy (1 bit) and tag[RoB_WIDTH-1:0].
REQ-011 SHALL hard-wire x0: reads return busy=0 and value=0; commits and renames to x0 are ignored.
REQ-012 SHALL, on commit_en with commit_reg != 0, write commit_data to value[commit_reg] at the next edge.
REQ-013 SHALL clear busy[commit_reg] on commit only when busy is set and tag[commit_reg] == commit_index; otherwise the value is written and busy/tag are kept, since a younger producer is pending.
REQ-014 SHALL, on rename_en with rename_reg != 0, set busy[rename_reg]=1 and tag[rename_reg]=rename_index at the next edge.
REQ-015 SHALL give rename priority over commit for busy/tag when both target the same register in one cycle; the value write from the commit still occurs.
REQ-016 SHALL, on flush_signal, clear every busy bit at the next edge, ignore rename_en that cycle, and still perform the commit value write.
REQ-017 SHALL drive each lookup combinationally with zero latency. If the entry is not busy: busy=0, value=stored value. If busy and commit_en and commit_reg==rs and commit_index==tag: busy=0, value=commit_data (bypass). Otherwise busy=1 with tag=stored tag.
REQ-018 SHALL present lookups with pre-rename state, so an instruction whose rd equals its rs reads the old producer.
REQ-019 SHALL apply no commit, rename or flush while rdy_in is low; lookups remain combinationally valid.

Reset
REQ-020 SHALL, on rst_in at a clock edge, clear all values to 0, all busy bits to 0 and all tags to 0, taking priority over rdy_in and flush_signal.
REQ-021 SHALL, during and after reset with no other activity, read rs*_busy=0, rs*_tag=0 and rs*_value=0 for every register.

Structure
REQ-022 SHALL take RoB_WIDTH and the 5-bit register index width from the shared CPU parameter package also used by the reorder buffer and dispatcher.
REQ-023 SHALL be a single module with no sub-modules; the two lookup ports are instances of one lookup function or generate block.

Verification
REQ-024 SHALL show rename then commit: rename x5->tag 2, then commit x5 tag 2 data 0xDEADBEEF -> next cycle rs1=5 gives busy=0, value=0xDEADBEEF.
REQ-025 SHALL show a stale commit: rename x5->tag 2, rename x5->tag 4, commit x5 tag 2 data 7 -> rs1=5 gives busy=1, tag=4.
REQ-026 SHALL show the bypass: x6 busy with tag 3, and in the same cycle commit x6 tag 3 data 0x55 with rs2=6 -> rs2_busy=0, rs2_value=0x55 combinationally.
REQ-027 SHALL show flush: x1..x3 renamed, then flush_signal with rename_en for x4 -> all busy=0 and x4 not busy.
REQ-028 SHALL show x0: rename x0->tag 1 and commit x0 data 9 -> rs1=0 gives busy=0, value=0.
REQ-029 SHALL show freeze: with rdy_in=0, commit x7 data 3 -> x7 unchanged; rst_in mid-sequence -> all entries read 0 and not busy.

Source files
------------

// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared CPU widths for the reorder buffer, dispatcher and register file
package register_file_pkg;

    localparam int ROB_WIDTH = 3;
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register file with rename busy/tag tracking and commit bypass
module register_file
    import register_file_pkg::*;
#(
    parameter int RoB_WIDTH = ROB_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 commit_en,
    input  logic [REG_IDX_W-1:0] commit_reg,
    input  logic [RoB_WIDTH-1:0] commit_index,
    input  logic [XLEN-1:0]      commit_data,
    input  logic                 rename_en,
    input  logic [REG_IDX_W-1:0] rename_reg,
    input  logic [RoB_WIDTH-1:0] rename_index,
    input  logic                 flush_signal,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 rs1_busy,
    output logic [RoB_WIDTH-1:0] rs1_tag,
    output logic [XLEN-1:0]      rs1_value,
    output logic                 rs2_busy,
    output logic [RoB_WIDTH-1:0] rs2_tag,
    output logic [XLEN-1:0]      rs2_value
);

    localparam int LW = 1 + RoB_WIDTH + XLEN;

    logic [XLEN-1:0]      r_value [NUM_REGS];
    logic [RoB_WIDTH-1:0] r_tag   [NUM_REGS];
    logic [NUM_REGS-1:0]  r_busy;

    logic w_commit_ok;
    logic w_rename_ok;
    logic [LW-1:0] w_lk1;
    logic [LW-1:0] w_lk2;

    assign w_commit_ok = commit_en && (commit_reg != '0);
    assign w_rename_ok = rename_en && (rename_reg != '0) && !flush_signal;

    // Rename and flush are applied after the commit so they win on busy/tag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_busy <= '0;
        end else if (rdy_in) begin
            if (w_commit_ok) begin
                r_value[commit_reg] <= commit_data;
                if (r_busy[commit_reg] && (r_tag[commit_reg] == commit_index))
                    r_busy[commit_reg] <= 1'b0;
            end
            if (flush_signal) begin
                r_busy <= '0;
            end else if (w_rename_ok) begin
                r_busy[rename_reg] <= 1'b1;
                r_tag[rename_reg]  <= rename_index;
            end
        end
    end

    // Returns {busy, tag, value}; a commit landing this cycle resolves a matching pending entry.
    function automatic logic [LW-1:0] lookup(input logic [REG_IDX_W-1:0] rs);
        logic [LW-1:0] res;
        res = '0;
        if (rs != '0) begin
            if (!r_busy[rs]) begin
                res = {1'b0, r_tag[rs], r_value[rs]};
            end else if (commit_en && (commit_reg == rs) && (commit_index == r_tag[rs])) begin
                res = {1'b0, r_tag[rs], commit_data};
            end else begin
                res = {1'b1, r_tag[rs], r_value[rs]};
            end
        end
        return res;
    endfunction

    assign w_lk1 = lookup(rs1);
    assign w_lk2 = lookup(rs2);

    assign {rs1_busy, rs1_tag, rs1_value} = w_lk1;
    assign {rs2_busy, rs2_tag, rs2_value} = w_lk2;

endmodule : register_file

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        commit_en;
    logic [4:0]  commit_reg;
    logic [2:0]  commit_index;
    logic [31:0] commit_data;
    logic        rename_en;
    logic [4:0]  rename_reg;
    logic [2:0]  rename_index;
    logic        flush_signal;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic [2:0]  rs1_tag, rs2_tag;
    logic [31:0] rs1_value, rs2_value;

    int checks = 0;
    int failures = 0;

    register_file #(.RoB_WIDTH(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .commit_en(commit_en), .commit_reg(commit_reg),
        .commit_index(commit_index), .commit_data(commit_data),
        .rename_en(rename_en), .rename_reg(rename_reg), .rename_index(rename_index),
        .flush_signal(flush_signal), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_value(rs1_value),
        .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_value(rs2_value)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic chk1(input string name, input logic b, input logic [2:0] t, input logic [31:0] v,
                        input logic chk_tag);
        check({name, "_rs1_busy"}, {31'b0, rs1_busy}, {31'b0, b});
        if (chk_tag) check({name, "_rs1_tag"}, {29'b0, rs1_tag}, {29'b0, t});
        if (!b) check({name, "_rs1_value"}, rs1_value, v);
    endtask

    task automatic chk2(input string name, input logic b, input logic [2:0] t, input logic [31:0] v,
                        input logic chk_tag);
        check({name, "_rs2_busy"}, {31'b0, rs2_busy}, {31'b0, b});
        if (chk_tag) check({name, "_rs2_tag"}, {29'b0, rs2_tag}, {29'b0, t});
        if (!b) check({name, "_rs2_value"}, rs2_value, v);
    endtask

    task automatic idle();
        commit_en = 0; rename_en = 0; flush_signal = 0;
    endtask

    initial begin
        rst_in = 1; rdy_in = 1; idle();
        commit_reg = 0; commit_index = 0; commit_data = 0;
        rename_reg = 0; rename_index = 0; rs1 = 5; rs2 = 31;
        step();
        chk1("reset_x5", 0, 0, 0, 1);
        chk2("reset_x31", 0, 0, 0, 1);
        rst_in = 0;
        step();
        chk1("post_reset_x5", 0, 0, 0, 1);

        // rename then commit
        rename_en = 1; rename_reg = 5; rename_index = 2;
        step();
        chk1("rename_x5", 1, 2, 0, 1);
        idle(); commit_en = 1; commit_reg = 5; commit_index = 2; commit_data = 32'hDEADBEEF;
        #1;
        chk1("bypass_x5", 0, 0, 32'hDEADBEEF, 0);
        step(); idle();
        chk1("commit_x5", 0, 0, 32'hDEADBEEF, 0);

        // stale commit keeps younger producer
        rename_en = 1; rename_reg = 5; rename_index = 2;
        step();
        rename_index = 4;
        step(); idle();
        commit_en = 1; commit_reg = 5; commit_index = 2; commit_data = 7;
        step(); idle();
        chk1("stale_commit_x5", 1, 4, 0, 1);

        // same-register rename and commit: lookup sees pre-rename state, rename wins busy/tag
        commit_en = 1; commit_reg = 5; commit_index = 4; commit_data = 32'h11;
        rename_en = 1; rename_reg = 5; rename_index = 6;
        #1;
        chk1("pre_rename_x5", 0, 0, 32'h11, 0);
        step(); idle();
        chk1("rename_over_commit_x5", 1, 6, 0, 1);
        commit_en = 1; commit_reg = 5; commit_index = 6; commit_data = 32'h22;
        step(); idle();
        chk1("commit_tag6_x5", 0, 0, 32'h22, 0);

        // combinational bypass on rs2
        rename_en = 1; rename_reg = 6; rename_index = 3; rs2 = 6;
        step(); idle();
        chk2("rename_x6", 1, 3, 0, 1);
        commit_en = 1; commit_reg = 6; commit_index = 3; commit_data = 32'h55;
        #1;
        chk2("bypass_x6", 0, 0, 32'h55, 0);
        step(); idle();
        chk2("commit_x6", 0, 0, 32'h55, 0);

        // flush clears all busy, drops same-cycle rename, keeps commit value write
        rename_en = 1;
        rename_reg = 1; rename_index = 1; step();
        rename_reg = 2; rename_index = 2; step();
        rename_reg = 3; rename_index = 3; step();
        rs1 = 1; rs2 = 3; #1;
        chk1("renamed_x1", 1, 1, 0, 1);
        chk2("renamed_x3", 1, 3, 0, 1);
        flush_signal = 1; rename_reg = 4; rename_index = 5;
        commit_en = 1; commit_reg = 7; commit_index = 0; commit_data = 32'hABC;
        step(); idle();
        chk1("flush_x1", 0, 0, 0, 0);
        chk2("flush_x3", 0, 0, 0, 0);
        rs1 = 2; rs2 = 4; #1;
        chk1("flush_x2", 0, 0, 0, 0);
        chk2("flush_x4", 0, 0, 0, 0);
        rs1 = 7; #1;
        chk1("flush_commit_x7", 0, 0, 32'hABC, 0);

        // x0 hard-wired
        rename_en = 1; rename_reg = 0; rename_index = 1;
        commit_en = 1; commit_reg = 0; commit_index = 1; commit_data = 9;
        rs1 = 0; #1;
        chk1("x0_same_cycle", 0, 0, 0, 1);
        step(); idle();
        chk1("x0", 0, 0, 0, 1);

        // freeze with rdy_in low
        rdy_in = 0;
        commit_en = 1; commit_reg = 7; commit_index = 0; commit_data = 3;
        rename_en = 1; rename_reg = 8; rename_index = 2;
        step(); idle();
        rs1 = 7; rs2 = 8; #1;
        chk1("freeze_x7", 0, 0, 32'hABC, 0);
        chk2("freeze_x8", 0, 0, 0, 1);
        rdy_in = 1;
        rename_en = 1; rename_reg = 9; rename_index = 5;
        step(); idle();
        rs2 = 9; #1;
        chk2("rename_x9", 1, 5, 0, 1);

        // reset overrides rdy_in and flush
        rst_in = 1; rdy_in = 0; flush_signal = 1;
        step();
        rst_in = 0; rdy_in = 1; idle();
        rs1 = 7; rs2 = 9; #1;
        chk1("rst_x7", 0, 0, 0, 1);
        chk2("rst_x9", 0, 0, 0, 1);
        rs1 = 5; rs2 = 6; #1;
        chk1("rst_x5", 0, 0, 0, 1);
        chk2("rst_x6", 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_register_file
